// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone bus-ownership arbiter with a grant held for the whole CYC cycle.
// Define WB_ARB_TIMEOUT_EN to build the watchdog that ends transactions stalled for TIMEOUT cycles.
module wb_arbiter_rr #(
    parameter int NUMM    = 3,
    parameter int TIMEOUT = 255,
    localparam int IW     = (NUMM > 1) ? $clog2(NUMM) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NUMM-1:0] cyc_i,
    input  logic [NUMM-1:0] stb_i,
    input  logic            ack_i,
    input  logic            err_i,
    output logic [NUMM-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            gnt_valid_o,
    output logic            to_err_o
);

    // Valid/ready contract: the owner's transfer completes in a cycle where
    // stb_i[owner] and (ack_i or err_i) are both high; the grant only moves on CYC drop.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t          state_q;
    logic [NUMM-1:0] gnt_q;
    logic [IW-1:0]   idx_q;
    logic            valid_q;
    logic [IW-1:0]   ptr_q;

    logic [IW-1:0]   ptr_d;
    logic [IW:0]     idle_pick;
    logic [IW:0]     rel_pick;
    logic            own_cyc;
    logic            own_stb;
    logic            fire;

    // Returns {found, index}: first requester at or above start, wrapping modulo NUMM.
    function automatic logic [IW:0] pick(input logic [NUMM-1:0] req, input logic [IW-1:0] start);
        logic [IW:0] r;
        r = '0;
        for (int k = NUMM - 1; k >= 0; k--) begin
            int m;
            m = (int'(start) + k) % NUMM;
            if (req[m]) r = {1'b1, IW'(m)};
        end
        return r;
    endfunction

    assign own_cyc   = cyc_i[idx_q];
    assign own_stb   = stb_i[idx_q];
    assign ptr_d     = (idx_q == IW'(NUMM - 1)) ? '0 : idx_q + 1'b1;
    assign idle_pick = pick(cyc_i, ptr_q);
    assign rel_pick  = pick(cyc_i, ptr_d);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic          stall;

    assign stall = own_stb & ~ack_i & ~err_i;
    // Fires in the stalled cycle that would bring the count to TIMEOUT, so a same-cycle ACK wins.
    assign fire  = (state_q == S_OWN) && own_cyc && stall && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q != S_OWN || !own_cyc || !stall || fire) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic unused_wdog;

    assign fire        = 1'b0;
    assign unused_wdog = ^{stb_i, ack_i, err_i, own_stb, 16'(TIMEOUT)};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (idle_pick[IW]) begin
                        gnt_q   <= {{(NUMM - 1){1'b0}}, 1'b1} << idle_pick[IW-1:0];
                        idx_q   <= idle_pick[IW-1:0];
                        valid_q <= 1'b1;
                        state_q <= S_OWN;
                    end
                end
                S_OWN, S_ABORT: begin
                    if (!own_cyc) begin
                        ptr_q <= ptr_d;
                        if (rel_pick[IW]) begin
                            gnt_q   <= {{(NUMM - 1){1'b0}}, 1'b1} << rel_pick[IW-1:0];
                            idx_q   <= rel_pick[IW-1:0];
                            valid_q <= 1'b1;
                            state_q <= S_OWN;
                        end else begin
                            gnt_q   <= '0;
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else if (fire) begin
                        state_q <= S_ABORT;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = valid_q;
    assign to_err_o    = fire;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr (NUMM=3, TIMEOUT=4) with an expected-grant scoreboard.
module tb_wb_arbiter_rr;

    localparam int NUMM = 3;
    localparam int IW   = 2;
    localparam int W    = NUMM + IW + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NUMM-1:0] cyc_i;
    logic [NUMM-1:0] stb_i;
    logic            ack_i;
    logic            err_i;
    logic [NUMM-1:0] gnt_o;
    logic [IW-1:0]   gnt_idx_o;
    logic            gnt_valid_o;
    logic            to_err_o;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic wd_on;

    wb_arbiter_rr #(.NUMM(NUMM), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cyc_i       (cyc_i),
        .stb_i       (stb_i),
        .ack_i       (ack_i),
        .err_i       (err_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o),
        .to_err_o    (to_err_o)
    );

    always #5 clk = ~clk;

    // Expected {grant, index, valid} derived from a one-hot grant.
    function automatic logic [W-1:0] pack(input logic [NUMM-1:0] g);
        logic [IW-1:0] ix;
        ix = '0;
        for (int m = 0; m < NUMM; m++) if (g[m]) ix = IW'(m);
        return {g, ix, |g};
    endfunction

    task automatic check_out(input string tag);
        logic [W-1:0] e;
        logic [W-1:0] o;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s scoreboard empty observed=%b", tag, gnt_o);
        end else begin
            e = exp_q.pop_front();
            o = {gnt_o, gnt_valid_o ? gnt_idx_o : {IW{1'b0}}, gnt_valid_o};
            assert (o === e) else begin
                n_err++;
                $error("FAIL %s grant observed=%b expected=%b", tag, o, e);
            end
        end
    endtask

    // Entered at a negedge: drive inputs, check to_err for this cycle, check grant after the edge.
    task automatic step(input logic [NUMM-1:0] cyc, input logic [NUMM-1:0] stb, input logic ack,
                        input logic [NUMM-1:0] egnt, input logic eto, input string tag);
        cyc_i = cyc;
        stb_i = stb;
        ack_i = ack;
        err_i = 1'b0;
        exp_q.push_back(pack(egnt));
        #1;
        n_cmp++;
        assert (to_err_o === eto) else begin
            n_err++;
            $error("FAIL %s to_err observed=%b expected=%b", tag, to_err_o, eto);
        end
        @(posedge clk);
        @(negedge clk);
        check_out(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc_i = '0;
        stb_i = '0;
        ack_i = 1'b0;
        err_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
`ifdef WB_ARB_TIMEOUT_EN
        wd_on = 1'b1;
`else
        wd_on = 1'b0;
`endif
        rst_n = 1'b0;
        cyc_i = '0;
        stb_i = '0;
        ack_i = 1'b0;
        err_i = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        assert ({gnt_o, gnt_idx_o, gnt_valid_o, to_err_o} === {3'b000, 2'b00, 1'b0, 1'b0}) else begin
            n_err++;
            $error("FAIL reset observed=%b%b%b%b expected=000_00_0_0", gnt_o, gnt_idx_o, gnt_valid_o, to_err_o);
        end
        rst_n = 1'b1;

        // Single requester
        step(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, "idle");
        step(3'b010, 3'b000, 1'b0, 3'b010, 1'b0, "single_gnt");
        for (int i = 0; i < 3; i++) step(3'b010, 3'b000, 1'b0, 3'b010, 1'b0, "single_hold");
        step(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, "single_rel");

        // Simultaneous requests from a fresh pointer: order 0,1,2,0 with no idle gap
        do_reset();
        step(3'b111, 3'b000, 1'b0, 3'b001, 1'b0, "rr_m0");
        for (int i = 0; i < 3; i++) step(3'b111, 3'b000, 1'b0, 3'b001, 1'b0, "rr_m0_hold");
        step(3'b110, 3'b000, 1'b0, 3'b010, 1'b0, "rr_m1");
        for (int i = 0; i < 3; i++) step(3'b111, 3'b000, 1'b0, 3'b010, 1'b0, "rr_m1_hold");
        step(3'b101, 3'b000, 1'b0, 3'b100, 1'b0, "rr_m2");
        for (int i = 0; i < 3; i++) step(3'b111, 3'b000, 1'b0, 3'b100, 1'b0, "rr_m2_hold");
        step(3'b011, 3'b000, 1'b0, 3'b001, 1'b0, "rr_m0_again");
        step(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, "rr_rel");

        // Hold during tenure: pointer is now 1, so master 2 wins alone
        step(3'b100, 3'b000, 1'b0, 3'b100, 1'b0, "hold_m2");
        for (int i = 0; i < 3; i++) step(3'b101, 3'b000, 1'b0, 3'b100, 1'b0, "hold_ignore_m0");
        step(3'b001, 3'b000, 1'b0, 3'b001, 1'b0, "hold_next_m0");
        step(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, "hold_rel");

        // Watchdog: pointer 1, master 1 stalls four cycles
        step(3'b010, 3'b000, 1'b0, 3'b010, 1'b0, "wd_gnt");
        for (int i = 0; i < 3; i++) step(3'b010, 3'b010, 1'b0, 3'b010, 1'b0, "wd_stall");
        step(3'b010, 3'b010, 1'b0, 3'b010, wd_on, "wd_fire");
        step(3'b010, 3'b010, 1'b1, 3'b010, 1'b0, "wd_abort_hold");
        step(3'b010, 3'b010, 1'b0, 3'b010, 1'b0, "wd_abort_hold2");
        step(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, "wd_rel");

        // ACK in the fourth stalled cycle suppresses the error and restarts the count
        step(3'b100, 3'b000, 1'b0, 3'b100, 1'b0, "race_gnt");
        for (int i = 0; i < 3; i++) step(3'b100, 3'b100, 1'b0, 3'b100, 1'b0, "race_stall");
        step(3'b100, 3'b100, 1'b1, 3'b100, 1'b0, "race_ack");
        for (int i = 0; i < 3; i++) step(3'b100, 3'b100, 1'b0, 3'b100, 1'b0, "race_restall");
        step(3'b100, 3'b100, 1'b0, 3'b100, wd_on, "race_fire");
        step(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, "race_rel");

        // Asynchronous reset in the middle of a tenure
        step(3'b001, 3'b000, 1'b0, 3'b001, 1'b0, "arst_gnt");
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        assert ({gnt_o, gnt_valid_o} === 4'b0000) else begin
            n_err++;
            $error("FAIL arst_clear observed=%b%b expected=0000", gnt_o, gnt_valid_o);
        end
        #1 rst_n = 1'b1;
        cyc_i = 3'b110;
        exp_q.push_back(pack(3'b010));
        @(posedge clk);
        @(negedge clk);
        check_out("arst_ptr0");
        step(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, "arst_rel");

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL leftover observed=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
